// File: rtl/alu_issue_stage.sv
// alu_issue_stage: operand issue + writeback stage with an 8x32 regfile and forwarding.
// Ports: instr valid/ready in, registered ALU operands out, ALU result in, wb valid/ready out.
module alu_issue_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [15:0]      instr,
    output logic [XLEN-1:0]  alu_a,
    output logic [XLEN-1:0]  alu_b,
    output logic [1:0]       alu_op,
    input  logic [XLEN-1:0]  alu_result,
    input  logic             alu_zero,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [2:0]       wb_rd,
    output logic [XLEN-1:0]  wb_data,
    output logic             wb_zero,
    output logic [CNT_W-1:0] retire_cnt,
    input  logic [2:0]       dbg_addr,
    output logic [XLEN-1:0]  dbg_data
);

    logic [XLEN-1:0] rf [8];
    logic            ex_valid;
    logic [2:0]      ex_rd;

    logic            imm_sel;
    logic [1:0]      op;
    logic [2:0]      rd;
    logic [2:0]      rs1;
    logic [2:0]      rs2;
    logic [XLEN-1:0] imm;

    logic            wb_free;
    logic            ex_adv;
    logic            issue;
    logic            retire;
    logic [XLEN-1:0] opa;
    logic [XLEN-1:0] opb;

    assign imm_sel = instr[15];
    assign op      = instr[14:13];
    assign rd      = instr[12:10];
    assign rs1     = instr[9:7];
    assign rs2     = instr[6:4];
    assign imm     = {{(XLEN-7){1'b0}}, instr[6:0]};

    assign wb_free     = !wb_valid || wb_ready;
    assign ex_adv      = ex_valid && wb_free;
    assign instr_ready = !ex_valid || wb_free;
    assign issue       = instr_valid && instr_ready;
    assign retire      = wb_valid && wb_ready;

    // The instruction in EX has not reached the regfile yet; its result is
    // live on alu_result, so dependent reads take it from there.
    function automatic logic [XLEN-1:0] fwd(input logic [2:0] r);
        if (r == 3'd0)
            return '0;
        else if (ex_valid && ex_rd == r)
            return alu_result;
        else
            return rf[r];
    endfunction

    always_comb begin
        opa = fwd(rs1);
        opb = imm_sel ? imm : fwd(rs2);
    end

    assign dbg_data = (dbg_addr == 3'd0) ? '0 : rf[dbg_addr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++)
                rf[i] <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= '0;
            ex_valid   <= 1'b0;
            ex_rd      <= '0;
            wb_valid   <= 1'b0;
            wb_rd      <= '0;
            wb_data    <= '0;
            wb_zero    <= 1'b0;
            retire_cnt <= '0;
        end else begin
            if (issue) begin
                alu_a    <= opa;
                alu_b    <= opb;
                alu_op   <= op;
                ex_rd    <= rd;
                ex_valid <= 1'b1;
            end else if (ex_adv) begin
                ex_valid <= 1'b0;
            end

            if (ex_adv) begin
                wb_valid <= 1'b1;
                wb_rd    <= ex_rd;
                wb_data  <= alu_result;
                wb_zero  <= alu_zero;
                if (ex_rd != 3'd0)
                    rf[ex_rd] <= alu_result;
            end else if (retire) begin
                wb_valid <= 1'b0;
            end

            if (retire)
                retire_cnt <= retire_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed checks of alu_issue_stage against a small ALU
// model and hand-computed expectations.
module tb_alu_issue_stage;

    logic        clk;
    logic        rst_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [1:0]  alu_op;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic        wb_valid;
    logic        wb_ready;
    logic [2:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_zero;
    logic [15:0] retire_cnt;
    logic [2:0]  dbg_addr;
    logic [31:0] dbg_data;

    int checks   = 0;
    int failures = 0;

    alu_issue_stage #(.XLEN(32), .CNT_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .instr      (instr),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .alu_zero   (alu_zero),
        .wb_valid   (wb_valid),
        .wb_ready   (wb_ready),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .wb_zero    (wb_zero),
        .retire_cnt (retire_cnt),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External ALU: 0 add, 1 sub, 2 and, 3 or.
    always_comb begin
        alu_result = '0;
        case (alu_op)
            2'd0: alu_result = alu_a + alu_b;
            2'd1: alu_result = alu_a - alu_b;
            2'd2: alu_result = alu_a & alu_b;
            default: alu_result = alu_a | alu_b;
        endcase
        alu_zero = (alu_result == 32'd0);
    end

    localparam logic [1:0] ADD = 2'd0;
    localparam logic [1:0] SUB = 2'd1;
    localparam logic [1:0] AND = 2'd2;
    localparam logic [1:0] OR  = 2'd3;

    function automatic logic [15:0] enc_i(input logic [1:0] o, input logic [2:0] d,
                                          input logic [2:0] s1, input logic [6:0] im);
        return {1'b1, o, d, s1, im};
    endfunction

    function automatic logic [15:0] enc_r(input logic [1:0] o, input logic [2:0] d,
                                          input logic [2:0] s1, input logic [2:0] s2);
        return {1'b0, o, d, s1, s2, 4'b0};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reg(input string tag, input logic [2:0] r, input logic [31:0] exp);
        dbg_addr = r;
        #1;
        chk(tag, dbg_data, exp);
    endtask

    initial begin
        rst_n       = 1'b0;
        instr_valid = 1'b1;
        instr       = enc_i(ADD, 3'd1, 3'd0, 7'd9);
        wb_ready    = 1'b0;
        dbg_addr    = 3'd0;

        // Reset with a pending instruction
        step();
        step();
        chk("rst_instr_ready", {31'b0, instr_ready}, 32'd1);
        chk("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_alu_b", alu_b, 32'd0);
        chk("rst_alu_op", {30'b0, alu_op}, 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_wb_rd", {29'b0, wb_rd}, 32'd0);
        chk("rst_wb_zero", {31'b0, wb_zero}, 32'd0);
        chk("rst_retire", {16'b0, retire_cnt}, 32'd0);
        for (int i = 0; i < 8; i++)
            chk_reg("rst_dbg", 3'(i), 32'd0);
        instr_valid = 1'b0;
        rst_n = 1'b1;
        step();
        chk("post_rst_ready", {31'b0, instr_ready}, 32'd1);

        // Immediate ops
        wb_ready    = 1'b1;
        instr_valid = 1'b1;
        instr       = enc_i(ADD, 3'd1, 3'd0, 7'd5);
        step();
        chk("imm1_alu_b", alu_b, 32'd5);
        instr = enc_i(ADD, 3'd2, 3'd0, 7'd3);
        step();
        chk("imm1_wb_valid", {31'b0, wb_valid}, 32'd1);
        chk("imm1_wb_data", wb_data, 32'd5);
        chk("imm1_wb_rd", {29'b0, wb_rd}, 32'd1);
        instr_valid = 1'b0;
        step();
        chk("imm2_wb_data", wb_data, 32'd3);
        chk("imm2_wb_rd", {29'b0, wb_rd}, 32'd2);
        step();
        chk("imm_wb_idle", {31'b0, wb_valid}, 32'd0);
        chk("imm_retire", {16'b0, retire_cnt}, 32'd2);
        chk_reg("imm_r1", 3'd1, 32'd5);
        chk_reg("imm_r2", 3'd2, 32'd3);

        // Forwarding: ADD r3,r1,#7 then SUB r4,r3,r3
        instr_valid = 1'b1;
        instr       = enc_i(ADD, 3'd3, 3'd1, 7'd7);
        step();
        chk("fwd_alu_a", alu_a, 32'd5);
        instr = enc_r(SUB, 3'd4, 3'd3, 3'd3);
        step();
        chk("fwd_wb_data1", wb_data, 32'd12);
        chk("fwd_sub_a", alu_a, 32'd12);
        chk("fwd_sub_b", alu_b, 32'd12);
        instr_valid = 1'b0;
        step();
        chk("fwd_wb_data2", wb_data, 32'd0);
        chk("fwd_wb_zero", {31'b0, wb_zero}, 32'd1);
        chk("fwd_wb_rd", {29'b0, wb_rd}, 32'd4);
        step();
        chk_reg("fwd_r3", 3'd3, 32'd12);
        chk("fwd_retire", {16'b0, retire_cnt}, 32'd4);

        // Back-pressure
        wb_ready    = 1'b0;
        instr_valid = 1'b1;
        instr       = enc_i(ADD, 3'd5, 3'd0, 7'd10);
        step();
        chk("bp_ready1", {31'b0, instr_ready}, 32'd1);
        instr = enc_i(ADD, 3'd6, 3'd0, 7'd20);
        step();
        chk("bp_ready_low", {31'b0, instr_ready}, 32'd0);
        instr = enc_i(ADD, 3'd7, 3'd0, 7'd30);
        step();
        chk("bp_hold_ready", {31'b0, instr_ready}, 32'd0);
        chk("bp_hold_data", wb_data, 32'd10);
        chk("bp_hold_b", alu_b, 32'd20);
        chk("bp_hold_retire", {16'b0, retire_cnt}, 32'd4);
        wb_ready = 1'b1;
        #1;
        chk("bp_release_ready", {31'b0, instr_ready}, 32'd1);
        step();
        instr_valid = 1'b0;
        chk("bp_rec2_data", wb_data, 32'd20);
        chk("bp_rec2_rd", {29'b0, wb_rd}, 32'd6);
        chk("bp_c_alu_b", alu_b, 32'd30);
        step();
        chk("bp_rec3_data", wb_data, 32'd30);
        chk("bp_rec3_rd", {29'b0, wb_rd}, 32'd7);
        step();
        chk("bp_idle", {31'b0, wb_valid}, 32'd0);
        chk("bp_retire", {16'b0, retire_cnt}, 32'd7);
        chk_reg("bp_r5", 3'd5, 32'd10);
        chk_reg("bp_r6", 3'd6, 32'd20);
        chk_reg("bp_r7", 3'd7, 32'd30);

        // r0 destination and OR/AND
        instr_valid = 1'b1;
        instr       = enc_i(OR, 3'd0, 3'd1, 7'h7F);
        step();
        instr = enc_i(AND, 3'd5, 3'd1, 7'd4);
        step();
        chk("or_wb_data", wb_data, 32'h7F);
        chk("or_wb_rd", {29'b0, wb_rd}, 32'd0);
        instr_valid = 1'b0;
        step();
        chk("and_wb_data", wb_data, 32'd4);
        step();
        chk_reg("r0_zero", 3'd0, 32'd0);
        chk_reg("and_r5", 3'd5, 32'd4);
        chk("or_and_retire", {16'b0, retire_cnt}, 32'd9);

        // Counter wrap: 9 + 65527 = 65536
        instr_valid = 1'b1;
        instr       = enc_i(ADD, 3'd1, 3'd0, 7'd1);
        for (int i = 0; i < 65527; i++)
            step();
        instr_valid = 1'b0;
        step();
        step();
        chk("wrap_retire", {16'b0, retire_cnt}, 32'd0);
        chk("wrap_idle", {31'b0, wb_valid}, 32'd0);

        // Reset while EX is occupied
        instr_valid = 1'b1;
        instr       = enc_i(ADD, 3'd2, 3'd0, 7'd9);
        step();
        chk("mid_alu_b", alu_b, 32'd9);
        instr_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_alu_b", alu_b, 32'd0);
        chk("mid_rst_ready", {31'b0, instr_ready}, 32'd1);
        step();
        rst_n = 1'b1;
        step();
        chk("mid_no_wb", {31'b0, wb_valid}, 32'd0);
        step();
        chk("mid_no_wb2", {31'b0, wb_valid}, 32'd0);
        chk_reg("mid_r2", 3'd2, 32'd0);
        chk("mid_retire", {16'b0, retire_cnt}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Operand-issue and writeback stage of the GMSK-P1 execute path. It accepts 16-bit ALU instructions over a valid/ready handshake, reads operands from an 8×32 register file, and drives the combinational ALU (`a`, `b`, `op`) from registers. It then captures `result`/`zero` into a writeback register with its own valid/ready handshake and writes the result back to the register file. Forwarding from the ALU output removes all read-after-write stalls.

## Interface
- `XLEN`, 32: datapath width; must equal the ALU width.
- `CNT_W`, 16: width of the retire counter.

- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset; single clock domain.
- `instr_valid`  in  1  upstream has an instruction.
- `instr_ready`  out  1  stage accepts the instruction this cycle.
- `instr`  in  16  instruction; fields below.
- `alu_a`  out  XLEN  to ALU `a`; registered.
- `alu_b`  out  XLEN  to ALU `b`; registered.
- `alu_op`  out  2  to ALU `op`; registered.
- `alu_result`  in  XLEN  from ALU `result`.
- `alu_zero`  in  1  from ALU `zero`.
- `wb_valid`  out  1  writeback record valid.
- `wb_ready`  in  1  consumer accepts the record.
- `wb_rd`  out  3  destination register of the record.
- `wb_data`  out  XLEN  result of the record.
- `wb_zero`  out  1  zero flag of the record.
- `retire_cnt`  out  CNT_W  count of records consumed.
- `dbg_addr`  in  3  debug read address.
- `dbg_data`  out  XLEN  combinational register-file read (r0 reads 0).

## Operation
- **Instruction fields**
  - [15] `imm_sel`, [14:13] `op`, [12:10] `rd`, [9:7] `rs1`, [6:4] `rs2`.
  - When `imm_sel`=1, operand B is `instr[6:0]` zero-extended to XLEN, and `rs2` is ignored.
- **Register file**
  - r1..r7 are XLEN-bit flops.
  - r0 always reads 0; writes to r0 are discarded.
- **Pipeline registers**
  - EX: `ex_valid`, `ex_rd`, `alu_a`, `alu_b`, `alu_op`.
  - WB: `wb_valid`, `wb_rd`, `wb_data`, `wb_zero`.
- **Advance conditions**
  - `wb_free` = !`wb_valid` | `wb_ready`.
  - `ex_adv` = `ex_valid` & `wb_free`.
  - `instr_ready` = !`ex_valid` | `wb_free` (combinational).
- **Issue** (on `instr_valid` & `instr_ready`):
  - Load `alu_a` = fwd(rs1) and `alu_b` = `imm_sel` ? imm : fwd(rs2).
  - Load `alu_op` = `op`, `ex_rd` = `rd`; set `ex_valid` = 1.
- **Forwarding**
  - fwd(r) = `alu_result` when `ex_valid` & `ex_rd`==r & r≠0; otherwise the regfile value.
  - Forwarding applies even while EX is stalled.
- **EX → WB** (on `ex_adv`):
  - `wb_valid`=1, `wb_rd`=`ex_rd`, `wb_data`=`alu_result`, `wb_zero`=`alu_zero`.
  - Regfile[`ex_rd`] ← `alu_result` on the same edge, unless `ex_rd`=0.
- **EX drain**
  - If `ex_adv` occurs without a new issue, `ex_valid` ← 0.
  - `alu_a`/`alu_b`/`alu_op` hold their last values.
- **WB drain**
  - If `wb_valid` & `wb_ready` occurs and there is no `ex_adv`, `wb_valid` ← 0.
  - Each `wb_valid` & `wb_ready` increments `retire_cnt` modulo 2^CNT_W (wraps to 0).
- **Stall**
  - When `wb_valid` & !`wb_ready`: WB holds, and EX holds if occupied.
  - `instr_ready` is 0 only when both stages are full.
- **Reset**
  - All regfile entries, `alu_a`, `alu_b`, `alu_op`, `ex_valid`, `ex_rd`, `wb_valid`, `wb_rd`, `wb_data`, `wb_zero` and `retire_cnt` = 0.
  - `instr_ready`=1 during and after reset.
  - Assertion mid-operation discards in-flight instructions immediately, with no regfile write.

## Timing
- **Throughput:** 1 instruction/cycle when `wb_ready` is held high.
- **Latency:**
  - Accepted at edge T → ALU inputs stable in cycle T..T+1.
  - `wb_valid`=1 after edge T+1.
  - Regfile updated at edge T+1.
- **Back-to-back dependency:** an instruction issued at T+1 reading `rd` receives the forwarded result. No bubble.
- **Simultaneous events:**
  - Issue + `ex_adv` on the same edge: EX reloads, WB loads the old EX contents.
  - Forwarding resolves against the old `ex_rd`.
- **Interface rule:** `instr` is sampled only on the handshake edge.

## Test plan
- **Reset:** assert `rst_n`=0 with `instr_valid`=1 → all outputs 0, `instr_ready`=1; `dbg_data`=0 for every address.
- **Immediate ops:** `wb_ready`=1; issue ADD r1,r0,#5 then ADD r2,r0,#3 → `wb_data` 5 then 3 on consecutive cycles; `retire_cnt`=2.
- **Forwarding:** issue ADD r3,r1,#7 then SUB r4,r3,r3 back-to-back (r1=5) → 12 then 0 with `wb_zero`=1; r3=12 after completion.
- **Back-pressure:** hold `wb_ready`=0 over 3 issues → `instr_ready` drops after 2 accepts; release → records retire in order, no loss or duplicate.
- **r0 and OR/AND ops:** OR r0,r1,#0x7F → `wb_data`=0x7F, `dbg_addr`=0 reads 0; AND r5,r1,#4 (r1=5) → 4.
- **Wrap and reset mid-op:** force 65536 retires → `retire_cnt`=0. Reset while `ex_valid`=1 → targeted register still 0 and no `wb_valid` afterwards.
